// File: rtl/fifo_sc_buf.sv
// ---------------------------------------------------------------------------
// fifo_sc_buf
//   Single-clock FIFO: 2**ASIZE entries of DSIZE bits with registered read
//   data. It stages data words between producer and consumer logic in the
//   ANN datapath. A write needs both wreq and the global valid strobe.
//
// Ports
//   clk     in   1      single clock, rising edge
//   rst     in   1      synchronous reset, active-high
//   valid   in   1      write qualifier; blocks writes only
//   wreq    in   1      write request
//   wdata   in   DSIZE  write data
//   rreq    in   1      read request
//   rdata   out  DSIZE  read data, registered; holds when no read fires
//   wfull   out  1      FIFO holds 2**ASIZE entries
//   rempty  out  1      FIFO holds 0 entries
// ---------------------------------------------------------------------------
module fifo_sc_buf #(
  parameter int DSIZE = 11,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rreq,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);

  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [DSIZE-1:0] rdata_r;
  logic [DSIZE-1:0] mem_r [DEPTH];

  logic             do_write_s;
  logic             do_read_s;
  logic             full_s;
  logic             empty_s;

  // Flags from registered pointers, and fire conditions evaluated pre-edge.
  always_comb begin
    empty_s    = (wptr_r == rptr_r);
    full_s     = (wptr_r[ASIZE] != rptr_r[ASIZE]) &&
                 (wptr_r[ASIZE-1:0] == rptr_r[ASIZE-1:0]);
    do_write_s = valid && wreq && !full_s;
    do_read_s  = rreq && !empty_s;
  end

  assign wfull  = full_s;
  assign rempty = empty_s;
  assign rdata  = rdata_r;

  // Write pointer: advances on each accepted write, wraps modulo 2**PW.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= {PW{1'b0}};
    end else if (do_write_s) begin
      wptr_r <= wptr_r + PW'(1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Read pointer and registered read data; rdata holds when no read fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_r  <= {PW{1'b0}};
      rdata_r <= {DSIZE{1'b0}};
    end else if (do_read_s) begin
      rptr_r  <= rptr_r + PW'(1);
      rdata_r <= mem_r[rptr_r[ASIZE-1:0]];
    end else begin
      rptr_r  <= rptr_r;
      rdata_r <= rdata_r;
    end
  end

  // Storage array; deliberately not reset, since reset only discards entries
  // by realigning the pointers.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem_r[wptr_r[ASIZE-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_fifo_sc_buf.sv
module tb_fifo_sc_buf;

  localparam int DSIZE = 11;
  localparam int ASIZE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic             wreq;
  logic [DSIZE-1:0] wdata;
  logic             rreq;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;

  int total_cnt  = 0;
  int passed_cnt = 0;

  fifo_sc_buf #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .wreq   (wreq),
    .wdata  (wdata),
    .rreq   (rreq),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
  );

  always #5 clk = ~clk;

  // One clock: inputs already set, sample on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      passed_cnt++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input int d, input logic r);
    valid = v;
    wreq  = w;
    wdata = DSIZE'(d);
    rreq  = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_rempty", 32'(rempty), 32'd1);
    chk("reset_wfull",  32'(wfull),  32'd0);
    chk("reset_rdata",  32'(rdata),  32'd0);

    // Write 1, then write 2 with a concurrent read.
    drive(1'b1, 1'b1, 1, 1'b0); cyc();
    chk("w1_rempty", 32'(rempty), 32'd0);
    drive(1'b1, 1'b1, 2, 1'b1); cyc();
    chk("rd1", 32'(rdata), 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1); cyc();
    chk("rd2", 32'(rdata), 32'd2);
    chk("rd2_rempty", 32'(rempty), 32'd1);

    // Interleaved writes 3..6 with reads.
    drive(1'b1, 1'b1, 3, 1'b0); cyc();
    chk("w3_rempty", 32'(rempty), 32'd0);
    drive(1'b1, 1'b1, 4, 1'b1); cyc();
    chk("rd3", 32'(rdata), 32'd3);
    drive(1'b1, 1'b1, 5, 1'b1); cyc();
    chk("rd4", 32'(rdata), 32'd4);
    drive(1'b1, 1'b1, 6, 1'b1); cyc();
    chk("rd5", 32'(rdata), 32'd5);
    drive(1'b1, 1'b0, 0, 1'b1); cyc();
    chk("rd6", 32'(rdata), 32'd6);
    chk("rd6_rempty", 32'(rempty), 32'd1);

    // valid=0 blocks the write; the following read finds nothing.
    drive(1'b0, 1'b1, 7, 1'b0); cyc();
    chk("novalid_rempty", 32'(rempty), 32'd1);
    drive(1'b0, 1'b0, 0, 1'b1); cyc();
    chk("novalid_rdata", 32'(rdata), 32'd6);
    chk("novalid_rempty2", 32'(rempty), 32'd1);

    // Fill and drain twice; pointers wrap during the second round.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, 1'b1, r * 16 + i, 1'b0); cyc();
        chk($sformatf("fill%0d_wfull_%0d", r, i), 32'(wfull), (i == 15) ? 32'd1 : 32'd0);
      end
      drive(1'b1, 1'b1, 99, 1'b0); cyc();
      chk($sformatf("drop%0d_wfull", r), 32'(wfull), 32'd1);
      for (int i = 0; i < 16; i++) begin
        // Round 1: first read coincides with a write while full; write drops.
        if (r == 1 && i == 0) drive(1'b1, 1'b1, 99, 1'b1);
        else drive(1'b1, 1'b0, 0, 1'b1);
        cyc();
        chk($sformatf("drain%0d_rd_%0d", r, i), 32'(rdata), 32'(r * 16 + i));
        chk($sformatf("drain%0d_wfull_%0d", r, i), 32'(wfull), 32'd0);
      end
      chk($sformatf("drain%0d_rempty", r), 32'(rempty), 32'd1);
    end
    drive(1'b1, 1'b0, 0, 1'b1); cyc();
    chk("empty_read_hold", 32'(rdata), 32'd31);

    // Simultaneous read and write while empty: only the write fires.
    drive(1'b1, 1'b1, 10, 1'b1); cyc();
    chk("empty_rw_rdata", 32'(rdata), 32'd31);
    chk("empty_rw_rempty", 32'(rempty), 32'd0);
    drive(1'b1, 1'b1, 11, 1'b0); cyc();
    drive(1'b1, 1'b1, 12, 1'b0); cyc();

    // Reset mid-stream with 3 entries stored.
    drive(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_rempty", 32'(rempty), 32'd1);
    chk("midrst_rdata",  32'(rdata),  32'd0);
    drive(1'b0, 1'b0, 0, 1'b1); cyc();
    chk("midrst_read_rdata",  32'(rdata),  32'd0);
    chk("midrst_read_rempty", 32'(rempty), 32'd1);
    drive(1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
